// File: rtl/id_stage_pkg.sv
// Shared opcode and funct3 constants for the RV32I decode stage.
// Also holds the small legality helpers used by id_decode.
package id_stage_pkg;

  typedef logic [6:0] opcode_t;

  localparam opcode_t INST_OP_IMM  = 7'b0010011;
  localparam opcode_t INST_OP      = 7'b0110011;
  localparam opcode_t INST_LOAD    = 7'b0000011;
  localparam opcode_t INST_STORE   = 7'b0100011;
  localparam opcode_t INST_BRANCH  = 7'b1100011;
  localparam opcode_t INST_JAL     = 7'b1101111;
  localparam opcode_t INST_JALR    = 7'b1100111;
  localparam opcode_t INST_LUI     = 7'b0110111;
  localparam opcode_t INST_AUIPC   = 7'b0010111;
  localparam opcode_t INST_ILLEGAL = 7'b1111111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // funct3 010 and 011 are the only holes in the branch group
  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/id_decode.sv
// Purely combinational RV32I decoder: control fields, immediates and rs-used flags.
// Operands that come from rs1/rs2 are flagged; all other operand values are produced here.
module id_decode
  import id_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  output logic [REG_AW-1:0] rd_addr,
  output logic              rs1_used,
  output logic              rs2_used,
  output logic              reg_wen,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic              illegal,
  output logic              op1_rs1,
  output logic              op2_rs2,
  output logic              base_rs1,
  output logic [XLEN-1:0]   op1_fix,
  output logic [XLEN-1:0]   op2_fix,
  output logic [XLEN-1:0]   base_fix,
  output logic [XLEN-1:0]   offset
);

  opcode_t         opcode;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic            wen_req;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign imm_i  = XLEN'($signed(inst[31:20]));
  assign imm_s  = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_j  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));

  // Every field stays zero unless the opcode row uses it, including on illegal encodings
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    wen_req  = 1'b0;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    illegal  = 1'b0;
    op1_rs1  = 1'b0;
    op2_rs2  = 1'b0;
    base_rs1 = 1'b0;
    op1_fix  = '0;
    op2_fix  = '0;
    base_fix = '0;
    offset   = '0;
    case (opcode)
      INST_OP_IMM: begin
        rs1_used = 1'b1;
        op1_rs1  = 1'b1;
        op2_fix  = ((f3 == F3_SLL) || (f3 == F3_SR)) ? XLEN'(inst[24:20]) : imm_i;
        wen_req  = 1'b1;
      end
      INST_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        op1_rs1  = 1'b1;
        op2_rs2  = 1'b1;
        wen_req  = 1'b1;
      end
      INST_LOAD: begin
        if (load_f3_ok(f3)) begin
          rs1_used = 1'b1;
          base_rs1 = 1'b1;
          offset   = imm_i;
          mem_ren  = 1'b1;
          wen_req  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      INST_STORE: begin
        if (store_f3_ok(f3)) begin
          rs1_used = 1'b1;
          rs2_used = 1'b1;
          base_rs1 = 1'b1;
          offset   = imm_s;
          op2_rs2  = 1'b1;
          mem_wen  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      INST_BRANCH: begin
        if (branch_f3_ok(f3)) begin
          rs1_used = 1'b1;
          rs2_used = 1'b1;
          op1_rs1  = 1'b1;
          op2_rs2  = 1'b1;
          base_fix = pc;
          offset   = imm_b;
        end else begin
          illegal = 1'b1;
        end
      end
      INST_JAL: begin
        base_fix = pc;
        offset   = imm_j;
        op1_fix  = pc;
        op2_fix  = XLEN'(4);
        wen_req  = 1'b1;
      end
      INST_JALR: begin
        if (f3 == F3_JALR) begin
          rs1_used = 1'b1;
          base_rs1 = 1'b1;
          offset   = imm_i;
          op1_fix  = pc;
          op2_fix  = XLEN'(4);
          wen_req  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      INST_LUI: begin
        op1_fix = imm_u;
        wen_req = 1'b1;
      end
      INST_AUIPC: begin
        op1_fix = pc;
        op2_fix = imm_u;
        wen_req = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign rs1_addr = rs1_used ? REG_AW'(inst[19:15]) : '0;
  assign rs2_addr = rs2_used ? REG_AW'(inst[24:20]) : '0;
  assign rd_addr  = wen_req ? REG_AW'(inst[11:7]) : '0;
  assign reg_wen  = wen_req && (inst[11:7] != 5'd0);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: EX->ID bypass, load-use / in-flight RAW interlock and the ID/EX register.
// Handshake is valid/ready on both sides; flush drops both the held and the incoming instruction.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  input  logic              flush_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              fwd_wen_i,
  input  logic [REG_AW-1:0] fwd_rd_i,
  input  logic [XLEN-1:0]   fwd_data_i,
  input  logic              fwd_load_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic [XLEN-1:0]   base_addr_o,
  output logic [XLEN-1:0]   offset_addr_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_wen_o,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  output logic              illegal_o
);

  logic [REG_AW-1:0] dec_rd;
  logic              rs1_used, rs2_used;
  logic              dec_wen, dec_ren, dec_mwen, dec_ill;
  logic              op1_rs1, op2_rs2, base_rs1;
  logic [XLEN-1:0]   op1_fix, op2_fix, base_fix, dec_offset;

  id_decode #(.XLEN(XLEN), .REG_AW(REG_AW)) u_decode (
    .inst     (inst_i),
    .pc       (inst_addr_i),
    .rs1_addr (rs1_addr_o),
    .rs2_addr (rs2_addr_o),
    .rd_addr  (dec_rd),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .reg_wen  (dec_wen),
    .mem_ren  (dec_ren),
    .mem_wen  (dec_mwen),
    .illegal  (dec_ill),
    .op1_rs1  (op1_rs1),
    .op2_rs2  (op2_rs2),
    .base_rs1 (base_rs1),
    .op1_fix  (op1_fix),
    .op2_fix  (op2_fix),
    .base_fix (base_fix),
    .offset   (dec_offset)
  );

  logic            rs1_live, rs2_live;
  logic            ex_hit1, ex_hit2;
  logic            haz1, haz2, hazard, advance, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign rs1_live = rs1_used && (rs1_addr_o != '0);
  assign rs2_live = rs2_used && (rs2_addr_o != '0);
  assign ex_hit1  = rs1_live && fwd_wen_i && (fwd_rd_i == rs1_addr_o);
  assign ex_hit2  = rs2_live && fwd_wen_i && (fwd_rd_i == rs2_addr_o);

  // The instruction sitting in ID/EX has no result yet, so a match against it must wait a cycle
  assign haz1 = (rs1_live && out_valid && reg_wen_o && (rd_addr_o == rs1_addr_o)) ||
                (ex_hit1 && (fwd_load_i || !FORWARD_EN));
  assign haz2 = (rs2_live && out_valid && reg_wen_o && (rd_addr_o == rs2_addr_o)) ||
                (ex_hit2 && (fwd_load_i || !FORWARD_EN));
  assign hazard = haz1 || haz2;

  assign rs1_val = (ex_hit1 && !fwd_load_i && FORWARD_EN) ? fwd_data_i : rs1_data_i;
  assign rs2_val = (ex_hit2 && !fwd_load_i && FORWARD_EN) ? fwd_data_i : rs2_data_i;

  assign advance  = !out_valid || out_ready;
  assign in_ready = flush_i || (advance && !hazard);
  assign accept   = in_valid && advance && !hazard && !flush_i;

  // Payload only changes on accept, so it is frozen while ex back-pressures
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      inst_o        <= '0;
      inst_addr_o   <= '0;
      base_addr_o   <= '0;
      offset_addr_o <= '0;
      op1_o         <= '0;
      op2_o         <= '0;
      rd_addr_o     <= '0;
      reg_wen_o     <= 1'b0;
      mem_ren_o     <= 1'b0;
      mem_wen_o     <= 1'b0;
      illegal_o     <= 1'b0;
    end else begin
      if (flush_i || advance) begin
        out_valid <= accept;
      end
      if (accept) begin
        inst_o        <= inst_i;
        inst_addr_o   <= inst_addr_i;
        base_addr_o   <= base_rs1 ? rs1_val : base_fix;
        offset_addr_o <= dec_offset;
        op1_o         <= op1_rs1 ? rs1_val : op1_fix;
        op2_o         <= op2_rs2 ? rs2_val : op2_fix;
        rd_addr_o     <= dec_rd;
        reg_wen_o     <= dec_wen;
        mem_ren_o     <= dec_ren;
        mem_wen_o     <= dec_mwen;
        illegal_o     <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: one bypassing and one non-bypassing instance driven in lockstep,
// directed walk through the main scenarios, then randomized traffic against a reference model.
module tb_id_stage;
  import id_stage_pkg::*;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wen;
    logic        ren;
    logic        mwen;
    logic        ill;
  } pay_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, fwd_wen, fwd_load, out_ready;
  logic [31:0] inst, pc, fwd_data, rs1_data, rs2_data;
  logic [4:0]  fwd_rd;

  logic [1:0]  in_ready_w, out_valid_w, wen_w, ren_w, mwen_w, ill_w;
  logic [4:0]  rs1_addr_w [2];
  logic [4:0]  rs2_addr_w [2];
  logic [4:0]  rd_w [2];
  logic [31:0] inst_w [2];
  logic [31:0] pc_w [2];
  logic [31:0] base_w [2];
  logic [31:0] off_w [2];
  logic [31:0] op1_w [2];
  logic [31:0] op2_w [2];

  logic [31:0] regs [32];
  pay_t        m_pay [2];
  logic        m_valid [2];
  logic [4:0]  cur_a1, cur_a2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .REG_AW(5), .FORWARD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .inst_i(inst), .inst_addr_i(pc), .flush_i(flush),
    .rs1_addr_o(rs1_addr_w[0]), .rs2_addr_o(rs2_addr_w[0]),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .fwd_wen_i(fwd_wen), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data), .fwd_load_i(fwd_load),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .inst_o(inst_w[0]), .inst_addr_o(pc_w[0]), .base_addr_o(base_w[0]),
    .offset_addr_o(off_w[0]), .op1_o(op1_w[0]), .op2_o(op2_w[0]),
    .rd_addr_o(rd_w[0]), .reg_wen_o(wen_w[0]), .mem_ren_o(ren_w[0]),
    .mem_wen_o(mwen_w[0]), .illegal_o(ill_w[0])
  );

  id_stage #(.XLEN(32), .REG_AW(5), .FORWARD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .inst_i(inst), .inst_addr_i(pc), .flush_i(flush),
    .rs1_addr_o(rs1_addr_w[1]), .rs2_addr_o(rs2_addr_w[1]),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .fwd_wen_i(fwd_wen), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data), .fwd_load_i(fwd_load),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .inst_o(inst_w[1]), .inst_addr_o(pc_w[1]), .base_addr_o(base_w[1]),
    .offset_addr_o(off_w[1]), .op1_o(op1_w[1]), .op2_o(op2_w[1]),
    .rd_addr_o(rd_w[1]), .reg_wen_o(wen_w[1]), .mem_ren_o(ren_w[1]),
    .mem_wen_o(mwen_w[1]), .illegal_o(ill_w[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string nm(input int d);
    return (d == 0) ? "fwd" : "nofwd";
  endfunction

  // Reference decode straight from the instruction table; v1/v2 are the resolved rs values
  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                     input logic [31:0] v1, input logic [31:0] v2,
                                     output logic u1, output logic u2, output pay_t r);
    logic [2:0]  f3;
    logic [31:0] immi, imms, immb, immj, immu;
    logic        w;
    f3   = ins[14:12];
    immi = {{20{ins[31]}}, ins[31:20]};
    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    immu = {ins[31:12], 12'b0};
    r = '0;
    r.inst = ins;
    r.pc = p;
    u1 = 1'b0;
    u2 = 1'b0;
    w = 1'b0;
    case (ins[6:0])
      7'h13: begin u1 = 1; r.op1 = v1; r.op2 = (f3 == 1 || f3 == 5) ? {27'b0, ins[24:20]} : immi; w = 1; end
      7'h33: begin u1 = 1; u2 = 1; r.op1 = v1; r.op2 = v2; w = 1; end
      7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin
               u1 = 1; r.base = v1; r.offset = immi; r.ren = 1; w = 1;
             end else r.ill = 1;
      7'h23: if (f3 <= 2) begin
               u1 = 1; u2 = 1; r.base = v1; r.offset = imms; r.op2 = v2; r.mwen = 1;
             end else r.ill = 1;
      7'h63: if (f3 != 2 && f3 != 3) begin
               u1 = 1; u2 = 1; r.op1 = v1; r.op2 = v2; r.base = p; r.offset = immb;
             end else r.ill = 1;
      7'h6F: begin r.base = p; r.offset = immj; r.op1 = p; r.op2 = 4; w = 1; end
      7'h67: if (f3 == 0) begin
               u1 = 1; r.base = v1; r.offset = immi; r.op1 = p; r.op2 = 4; w = 1;
             end else r.ill = 1;
      7'h37: begin r.op1 = immu; w = 1; end
      7'h17: begin r.op1 = p; r.op2 = immu; w = 1; end
      default: r.ill = 1;
    endcase
    r.rd  = w ? ins[11:7] : 5'd0;
    r.wen = w && (ins[11:7] != 0);
  endfunction

  function automatic logic model_hazard(input int d, input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (m_valid[d] && m_pay[d].wen && m_pay[d].rd == a) return 1'b1;
    return fwd_wen && fwd_rd == a && (fwd_load || d == 1);
  endfunction

  function automatic logic [31:0] fwd_val(input int d, input logic [4:0] a);
    if (a != 0 && fwd_wen && fwd_rd == a && !fwd_load && d == 0) return fwd_data;
    return regs[a];
  endfunction

  function automatic pay_t act_pay(input int d);
    pay_t p;
    p.inst = inst_w[d]; p.pc = pc_w[d]; p.base = base_w[d]; p.offset = off_w[d];
    p.op1 = op1_w[d]; p.op2 = op2_w[d]; p.rd = rd_w[d];
    p.wen = wen_w[d]; p.ren = ren_w[d]; p.mwen = mwen_w[d]; p.ill = ill_w[d];
    return p;
  endfunction

  task automatic check_pay(input int d);
    pay_t a;
    a = act_pay(d);
    check({nm(d), ".inst"},   a.inst,   m_pay[d].inst);
    check({nm(d), ".pc"},     a.pc,     m_pay[d].pc);
    check({nm(d), ".base"},   a.base,   m_pay[d].base);
    check({nm(d), ".offset"}, a.offset, m_pay[d].offset);
    check({nm(d), ".op1"},    a.op1,    m_pay[d].op1);
    check({nm(d), ".op2"},    a.op2,    m_pay[d].op2);
    check({nm(d), ".ctl"},    32'({a.rd, a.wen, a.ren, a.mwen, a.ill}),
          32'({m_pay[d].rd, m_pay[d].wen, m_pay[d].ren, m_pay[d].mwen, m_pay[d].ill}));
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_pay[d]   = '0;
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                                input logic fl, input logic fw, input logic [4:0] frd,
                                input logic [31:0] fd, input logic fld, input logic ordy);
    logic u1, u2;
    pay_t tmp;
    in_valid = v; inst = ins; pc = p; flush = fl;
    fwd_wen = fw; fwd_rd = frd; fwd_data = fd; fwd_load = fld; out_ready = ordy;
    ref_decode(ins, p, 32'd0, 32'd0, u1, u2, tmp);
    cur_a1 = u1 ? ins[19:15] : 5'd0;
    cur_a2 = u2 ? ins[24:20] : 5'd0;
    rs1_data = regs[cur_a1];
    rs2_data = regs[cur_a2];
    #1;
  endtask

  // Compares the combinational side, clocks once, then compares the registered side
  task automatic check_output();
    pay_t np [2];
    logic nv [2];
    logic u1, u2, hz, rdy;
    for (int d = 0; d < 2; d++) begin
      hz  = model_hazard(d, cur_a1) || model_hazard(d, cur_a2);
      rdy = flush || ((!m_valid[d] || out_ready) && !hz);
      check({nm(d), ".in_ready"}, 32'(in_ready_w[d]), 32'(rdy));
      check({nm(d), ".rs1_addr"}, 32'(rs1_addr_w[d]), 32'(cur_a1));
      check({nm(d), ".rs2_addr"}, 32'(rs2_addr_w[d]), 32'(cur_a2));
      ref_decode(inst, pc, fwd_val(d, cur_a1), fwd_val(d, cur_a2), u1, u2, np[d]);
      nv[d] = m_valid[d];
      if (flush) nv[d] = 1'b0;
      else if (!m_valid[d] || out_ready) nv[d] = in_valid && !hz;
      if (!flush && (!m_valid[d] || out_ready) && in_valid && !hz) m_pay[d] = np[d];
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = nv[d];
      check({nm(d), ".out_valid"}, 32'(out_valid_w[d]), 32'(m_valid[d]));
      if (m_valid[d]) check_pay(d);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] random_inst();
    logic [31:0] r;
    logic [6:0]  opc;
    case ($urandom_range(0, 10))
      0: opc = 7'h13;  1: opc = 7'h33;  2: opc = 7'h03;  3: opc = 7'h23;
      4: opc = 7'h63;  5: opc = 7'h6F;  6: opc = 7'h67;  7: opc = 7'h37;
      8: opc = 7'h17;  9: opc = INST_ILLEGAL;
      default: opc = 7'h5B;
    endcase
    r = $urandom;
    r[6:0]   = opc;
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
  localparam logic [31:0] LW_X2   = 32'h0080_A103;
  localparam logic [31:0] ADD_X3  = 32'h0021_01B3;
  localparam logic [31:0] ADD_X4  = 32'h0000_8233;
  localparam logic [31:0] JAL_X1  = 32'h0100_00EF;
  localparam logic [31:0] ADDI_X5 = 32'h0070_0293;

  initial begin
    logic [31:0] ld_data;
    regs[0] = 32'd0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    model_reset();
    rst = 1'b1;
    in_valid = 0; inst = 0; pc = 0; flush = 0; fwd_wen = 0; fwd_rd = 0;
    fwd_data = 0; fwd_load = 0; out_ready = 1; rs1_data = 0; rs2_data = 0;
    cur_a1 = 0; cur_a2 = 0;
    #2;
    $display("[TB] reset state");
    for (int d = 0; d < 2; d++) begin
      check({nm(d), ".rst_out_valid"}, 32'(out_valid_w[d]), 32'd0);
      check({nm(d), ".rst_in_ready"}, 32'(in_ready_w[d]), 32'd1);
      check_pay(d);
    end
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] addi x1,x0,5");
    apply_stimulus(1, ADDI_X1, 32'h0, 0, 0, 0, 0, 0, 1);
    check_output();
    check("addi.out_valid", 32'(out_valid_w[0]), 32'd1);
    check("addi.op1", op1_w[0], 32'd0);
    check("addi.op2", op2_w[0], 32'd5);
    check("addi.rd", 32'(rd_w[0]), 32'd1);
    check("addi.reg_wen", 32'(wen_w[0]), 32'd1);

    apply_stimulus(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    check_output();

    $display("[TB] load-use stall");
    apply_stimulus(1, LW_X2, 32'h4, 0, 0, 0, 0, 0, 1);
    check("lw.in_ready", 32'(in_ready_w[0]), 32'd1);
    check_output();
    check("lw.mem_ren", 32'(ren_w[0]), 32'd1);
    check("lw.base", base_w[0], regs[1]);
    check("lw.offset", off_w[0], 32'd8);
    apply_stimulus(1, ADD_X3, 32'h8, 0, 0, 0, 0, 0, 1);
    check("add_handover.in_ready", 32'(in_ready_w[0]), 32'd0);
    check_output();
    ld_data = $urandom;
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1, ADD_X3, 32'h8, 0, 1, 5'd2, ld_data, 1, 1);
      check("add_loaduse.in_ready", 32'(in_ready_w[0]), 32'd0);
      check("add_loaduse.nf_in_ready", 32'(in_ready_w[1]), 32'd0);
      check_output();
    end
    regs[2] = ld_data;
    apply_stimulus(1, ADD_X3, 32'h8, 0, 0, 0, 0, 0, 1);
    check("add_release.in_ready", 32'(in_ready_w[0]), 32'd1);
    check_output();
    check("add_release.op1", op1_w[0], ld_data);
    check("add_release.op2", op2_w[0], ld_data);

    $display("[TB] forwarding");
    apply_stimulus(1, ADD_X4, 32'hC, 0, 1, 5'd1, 32'hDEAD, 0, 1);
    check("fwd.in_ready", 32'(in_ready_w[0]), 32'd1);
    check("nofwd.in_ready_stall", 32'(in_ready_w[1]), 32'd0);
    check_output();
    check("fwd.op1", op1_w[0], 32'hDEAD);
    check("nofwd.bubble", 32'(out_valid_w[1]), 32'd0);
    regs[1] = 32'hDEAD;
    apply_stimulus(1, ADD_X4, 32'hC, 0, 0, 0, 0, 0, 1);
    check("nofwd.in_ready_after", 32'(in_ready_w[1]), 32'd1);
    check_output();
    check("nofwd.out_valid", 32'(out_valid_w[1]), 32'd1);
    check("nofwd.op1", op1_w[1], 32'hDEAD);

    $display("[TB] jal");
    apply_stimulus(1, JAL_X1, 32'h100, 0, 0, 0, 0, 0, 1);
    check_output();
    check("jal.base", base_w[0], 32'h100);
    check("jal.offset", off_w[0], 32'd16);
    check("jal.op1", op1_w[0], 32'h100);
    check("jal.op2", op2_w[0], 32'd4);

    $display("[TB] back-pressure and flush");
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, ADDI_X5, 32'h104, 0, 0, 0, 0, 0, 0);
      check("stall.in_ready", 32'(in_ready_w[0]), 32'd0);
      check_output();
      check("stall.out_valid", 32'(out_valid_w[0]), 32'd1);
      check("stall.op1", op1_w[0], 32'h100);
    end
    apply_stimulus(1, ADDI_X5, 32'h104, 1, 0, 0, 0, 0, 0);
    check("flush.in_ready", 32'(in_ready_w[0]), 32'd1);
    check_output();
    check("flush.out_valid", 32'(out_valid_w[0]), 32'd0);
    apply_stimulus(0, 32'h0, 32'h108, 0, 0, 0, 0, 0, 1);
    check_output();
    check("flush.dropped", 32'(out_valid_w[0]), 32'd0);

    $display("[TB] illegal and async reset");
    apply_stimulus(1, {25'd0, 5'd1, 2'b11} | 32'(INST_ILLEGAL), 32'h200, 0, 0, 0, 0, 0, 1);
    check_output();
    check("ill.illegal", 32'(ill_w[0]), 32'd1);
    check("ill.reg_wen", 32'(wen_w[0]), 32'd0);
    check("ill.out_valid", 32'(out_valid_w[0]), 32'd1);
    apply_stimulus(1, ADDI_X5, 32'h204, 0, 0, 0, 0, 0, 0);
    check_output();
    apply_stimulus(1, ADDI_X5, 32'h204, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      check({nm(d), ".arst_out_valid"}, 32'(out_valid_w[d]), 32'd0);
      check_pay(d);
    end
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) regs[$urandom_range(1, 3)] = $urandom;
      apply_stimulus($urandom_range(0, 4) != 0, random_inst(), $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 12) == 0, $urandom_range(0, 1) == 1,
                     5'($urandom_range(0, 3)), $urandom, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) != 0);
      check_output();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Registered, handshaked decode stage for the RV32I core. It sits between if_id and ex. It decodes the full RV32I base set, including loads and stores. It computes branch and jump target operands, forwards results from the EX stage, and interlocks on load-use and in-flight RAW hazards. Results are held in an internal ID/EX register with valid/ready flow control and flush support.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width
- FORWARD_EN, 1, enables the EX→ID bypass; 0 = every EX match stalls

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  inst_i/inst_addr_i valid
- in_ready  out  1  stage accepts input this cycle
- inst_i  in  32  instruction
- inst_addr_i  in  XLEN  instruction PC
- flush_i  in  1  kill the held and the incoming instruction
- rs1_addr_o, rs2_addr_o  out  REG_AW  register file read addresses (combinational, from inst_i)
- rs1_data_i, rs2_data_i  in  XLEN  register file read data
- fwd_wen_i  in  1  EX instruction writes rd
- fwd_rd_i  in  REG_AW  EX destination
- fwd_data_i  in  XLEN  EX result
- fwd_load_i  in  1  EX instruction is a load; data not yet valid
- out_valid  out  1  registered outputs valid
- out_ready  in  1  ex accepts
- inst_o  out  32  registered instruction
- inst_addr_o  out  XLEN  registered PC
- base_addr_o, offset_addr_o  out  XLEN  address/target operands
- op1_o, op2_o  out  XLEN  ALU operands
- rd_addr_o  out  REG_AW  destination register
- reg_wen_o  out  1  register write enable
- mem_ren_o, mem_wen_o  out  1  load/store
- illegal_o  out  1  unsupported opcode or funct3

## Operation
Decode table:
- OP-IMM: op1=rs1, op2=immI; shifts use op2={27'b0,shamt}.
- OP: op1=rs1, op2=rs2.
- LOAD (0000011): base=rs1, offset=immI, mem_ren=1, wen=1.
- STORE (0100011): base=rs1, offset=immS, op2=rs2, mem_wen=1, wen=0.
- BRANCH: op1=rs1, op2=rs2, base=PC, offset=immB.
- JAL: base=PC, offset=immJ, op1=PC, op2=4.
- JALR: base=rs1, offset=immI, op1=PC, op2=4.
- LUI: op1=immU, op2=0.
- AUIPC: op1=PC, op2=immU.

Decode rules:
- Unused rs addresses and unused fields are driven to 0.
- Illegal encoding: illegal_o=1, reg_wen_o=mem_*=0. The instruction is passed valid so ex can trap.
- rd_addr_o=0 forces reg_wen_o=0.

Operand source, per used rs with nonzero address, in priority order:
- fwd_wen_i && fwd_rd_i==rs && !fwd_load_i && FORWARD_EN → use fwd_data_i.
- Otherwise → use rs*_data_i.

A hazard holds when a used rs is nonzero and either of these matches:
- (a) out_valid && reg_wen_o && rd_addr_o==rs. The instruction being handed over has no result yet.
- (b) fwd_wen_i && fwd_rd_i==rs && (fwd_load_i || !FORWARD_EN).

Handshake and register update:
- advance = !out_valid || out_ready.
- in_ready = flush_i || (advance && !hazard).
- On accept without flush: the register loads the decoded payload and out_valid←1.
- On advance with a hazard or !in_valid: out_valid←0 (bubble).
- If !advance: the register holds and outputs stay stable.
- flush_i: out_valid←0; any incoming instruction is consumed and discarded. This holds regardless of hazard or out_ready.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 per cycle without hazards.
- A load-use hazard stalls for as long as fwd_load_i matches.
- An in-flight RAW stalls for exactly 1 cycle after handover when FORWARD_EN=1.
- On reset, all registered outputs are 0 and out_valid=0. in_ready is therefore 1 after reset, subject to fwd_* hazards.
- rst asserted mid-stall clears the held instruction immediately.
- There is a combinational path out_ready→in_ready. This path is accepted.
- The payload must not change while out_valid && !out_ready.

## Structure
- Add opcode constants to defines.v: `INST_LOAD, `INST_STORE, load/store funct3 codes.
- Add an illegal-instruction constant to defines.v.
- Sub-module: id_decode, purely combinational. It takes the instruction and PC and produces the control fields, immediates and the rs-used flags.
- id_stage holds the forwarding mux, the hazard logic and the ID/EX register.

## Test plan
- addi x1,x0,5 accepted with out_ready=1 → next cycle out_valid=1, op1=0, op2=5, rd=1, reg_wen=1.
- lw x2,8(x1) immediately followed by add x3,x2,x2:
  - the add stalls while fwd_load_i=1 with fwd_rd_i=2;
  - after the stall, op1=op2 equal the registered rs data.
- add x4,x1,x0 while fwd_wen=1, fwd_rd=1, fwd_data=0xDEAD → op1=0xDEAD with no stall. The same stimulus with FORWARD_EN=0 → 1-cycle stall.
- jal x1,+16 at PC 0x100 → base=0x100, offset=16, op1=0x100, op2=4.
- out_ready=0 for 3 cycles → outputs stable and in_ready=0. flush_i asserted in that window → out_valid=0 next cycle and the incoming instruction is dropped.
- Opcode 0x7F → illegal_o=1, reg_wen=0, out_valid=1. Asserting rst mid-stall → all outputs 0 asynchronously.
